// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus bundle: redirect/halt control, branch predictor lookup,
// instruction memory request/response and instruction buffer push ports.
interface instruction_fetch_unit_if;
  logic        flush_i;
  logic [31:0] redirect_address_i;
  logic        halt_i;
  logic        bp_hit_i;
  logic        bp_taken_i;
  logic [31:0] bp_target_i;
  logic        fetch_valid_o;
  logic [31:0] fetch_address_o;
  logic        fetch_ready_i;
  logic        fetch_valid_i;
  logic [31:0] fetch_instruction_i;
  logic        buf_full_i;
  logic        buf_flush_o;
  logic        buf_write_address_o;
  logic        buf_write_spec_o;
  logic        buf_write_instr_o;
  logic [31:0] buf_address_o;
  logic [31:0] buf_instruction_o;
  logic        buf_speculative_o;
  logic        buf_taken_o;

  // Fetch unit side
  modport master (
    input  flush_i, redirect_address_i, halt_i,
    input  bp_hit_i, bp_taken_i, bp_target_i,
    input  fetch_ready_i, fetch_valid_i, fetch_instruction_i, buf_full_i,
    output fetch_valid_o, fetch_address_o,
    output buf_flush_o, buf_write_address_o, buf_write_spec_o, buf_write_instr_o,
    output buf_address_o, buf_instruction_o, buf_speculative_o, buf_taken_o
  );

  // Environment side (control, predictor, memory, buffer)
  modport slave (
    output flush_i, redirect_address_i, halt_i,
    output bp_hit_i, bp_taken_i, bp_target_i,
    output fetch_ready_i, fetch_valid_i, fetch_instruction_i, buf_full_i,
    input  fetch_valid_o, fetch_address_o,
    input  buf_flush_o, buf_write_address_o, buf_write_spec_o, buf_write_instr_o,
    input  buf_address_o, buf_instruction_o, buf_speculative_o, buf_taken_o
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues in-order fetches with prediction
// attached, and drops responses to requests orphaned by a flush.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_ADDRESS   = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input logic                      clk_i,
  input logic                      rst_n_i,
  instruction_fetch_unit_if.master bus
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] live_q, live_d;
  logic [CNT_W-1:0] discard_q, discard_d;

  logic [31:0]      fetch_address;
  logic [SUM_W-1:0] in_flight;
  logic [SUM_W-1:0] carried;
  logic             issue;
  logic             accept;
  logic             pred_taken;
  logic             resp_live;
  logic             resp_discard;
  logic             push_instr;

  // State, PC and outstanding-request counters
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= BOOT;
      pc_q      <= RESET_ADDRESS;
      live_q    <= '0;
      discard_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      live_q    <= live_d;
      discard_q <= discard_d;
    end
  end

  // Run-state transitions; a flush always wins over halt
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   if (bus.halt_i && !bus.flush_i) state_d = HALT;
      HALT:    if (bus.flush_i || !bus.halt_i) state_d = FETCH;
      default: state_d = BOOT;
    endcase
  end

  // Request issue and response classification
  always_comb begin
    fetch_address = bus.flush_i ? bus.redirect_address_i : pc_q;
    in_flight     = SUM_W'(live_q) + SUM_W'(discard_q);
    issue         = (state_q != BOOT)
                 && ((state_q == FETCH) || bus.flush_i)
                 && !(bus.halt_i && !bus.flush_i)
                 && !bus.buf_full_i
                 && (in_flight < SUM_W'(MAX_OUTSTANDING));
    accept        = issue && bus.fetch_ready_i;
    pred_taken    = bus.bp_hit_i && bus.bp_taken_i;
    resp_live     = bus.fetch_valid_i && (discard_q == '0);
    resp_discard  = bus.fetch_valid_i && (discard_q != '0);
    push_instr    = resp_live && !bus.flush_i;
  end

  // Next PC: the accepted request decides, otherwise a flush redirects
  always_comb begin
    pc_d = pc_q;
    if (accept) begin
      pc_d = pred_taken ? bus.bp_target_i : fetch_address + 32'd4;
    end else if (bus.flush_i) begin
      pc_d = bus.redirect_address_i;
    end
  end

  // On flush every live request becomes one to discard; the flush-cycle
  // accept is the only live one afterwards
  always_comb begin
    live_d    = live_q;
    discard_d = discard_q;
    carried   = in_flight;
    if (bus.flush_i) begin
      if (bus.fetch_valid_i && (in_flight != '0)) begin
        carried = in_flight - SUM_W'(1);
      end
      discard_d = CNT_W'(carried);
      live_d    = CNT_W'(accept);
    end else begin
      if (accept && !resp_live) begin
        live_d = live_q + CNT_W'(1);
      end else if (!accept && resp_live && (live_q != '0)) begin
        live_d = live_q - CNT_W'(1);
      end
      if (resp_discard) begin
        discard_d = discard_q - CNT_W'(1);
      end
    end
  end

  assign bus.fetch_valid_o       = issue;
  assign bus.fetch_address_o     = fetch_address;
  assign bus.buf_flush_o         = bus.flush_i;
  assign bus.buf_write_address_o = accept;
  assign bus.buf_write_spec_o    = accept;
  assign bus.buf_address_o       = fetch_address;
  assign bus.buf_speculative_o   = accept && bus.bp_hit_i;
  assign bus.buf_taken_o         = accept && pred_taken;
  assign bus.buf_write_instr_o   = push_instr;
  assign bus.buf_instruction_o   = push_instr ? bus.fetch_instruction_i : '0;

  // A response with nothing outstanding means memory broke the protocol
  a_no_orphan_response : assert property (
    @(posedge clk_i) disable iff (!rst_n_i)
      !(bus.fetch_valid_i && (live_q == '0) && (discard_q == '0))
  ) else $error("instruction_fetch_unit: response with no request outstanding");

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a latency-1 stallable memory
// model and scoreboards for buffer address entries and instruction pushes.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_ADDRESS = 32'h0000_0000;

  logic clk_i = 1'b0;
  logic rst_n_i;

  instruction_fetch_unit_if ifu ();

  instruction_fetch_unit #(
    .RESET_ADDRESS  (RESET_ADDRESS),
    .MAX_OUTSTANDING(4)
  ) dut (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .bus    (ifu)
  );

  always #5 clk_i = ~clk_i;

  // Predictor: a single entry looked up on the live fetch address
  logic        bp_en;
  logic [31:0] bp_pc;
  logic        bp_tk;
  logic [31:0] bp_tgt;
  assign ifu.bp_hit_i    = bp_en && (ifu.fetch_address_o == bp_pc);
  assign ifu.bp_taken_i  = bp_tk;
  assign ifu.bp_target_i = bp_tgt;

  typedef struct { logic [31:0] addr; logic spec; logic taken; } entry_t;
  typedef struct { logic [31:0] addr; int unsigned cyc; logic stale; } mem_req_t;
  typedef struct { logic push; logic [31:0] instr; } resp_t;

  entry_t      exp_addr_q[$];
  mem_req_t    mem_q[$];
  resp_t       resp_q[$];
  logic [31:0] push_log[$];
  entry_t      ent;
  mem_req_t    mem_r;
  resp_t       resp_e;
  int unsigned cyc = 0;
  bit          mem_stall;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      nxt();
      smp();
    end
  endtask

  task automatic expect_entry(input logic [31:0] a, input logic s, input logic t);
    exp_addr_q.push_back('{addr: a, spec: s, taken: t});
  endtask

  task automatic issue_check(input string tag, input logic [31:0] a);
    nxt();
    ifu.fetch_ready_i = 1'b1;
    smp();
    check({tag, "_valid"}, 32'(ifu.fetch_valid_o), 32'd1);
    check({tag, "_addr"}, ifu.fetch_address_o, a);
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Memory response side: one in-order response per cycle, at least a cycle after accept
  initial begin
    ifu.fetch_valid_i       = 1'b0;
    ifu.fetch_instruction_i = '0;
    forever begin
      @(posedge clk_i);
      #2;
      ifu.fetch_valid_i       = 1'b0;
      ifu.fetch_instruction_i = '0;
      if (rst_n_i && !mem_stall && (mem_q.size() > 0) && (mem_q[0].cyc < cyc)) begin
        mem_r = mem_q.pop_front();
        ifu.fetch_valid_i       = 1'b1;
        ifu.fetch_instruction_i = mem_data(mem_r.addr);
        resp_q.push_back('{push: !mem_r.stale && !ifu.flush_i, instr: mem_data(mem_r.addr)});
      end
    end
  end

  // Scoreboards plus memory request capture; requests older than a flush are stale
  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      mem_q.delete();
      resp_q.delete();
    end else begin
      if (resp_q.size() > 0) begin
        resp_e = resp_q.pop_front();
        check("instr_push", 32'(ifu.buf_write_instr_o), 32'(resp_e.push));
        if (resp_e.push) check("instr_data", ifu.buf_instruction_o, resp_e.instr);
      end else begin
        check("instr_idle", 32'(ifu.buf_write_instr_o), 32'd0);
      end
      if (ifu.buf_write_instr_o) push_log.push_back(ifu.buf_instruction_o);

      if (ifu.buf_write_address_o) begin
        check("entry_expected", 32'(exp_addr_q.size() != 0), 32'd1);
        if (exp_addr_q.size() != 0) begin
          ent = exp_addr_q.pop_front();
          check("entry_addr", ifu.buf_address_o, ent.addr);
          check("entry_spec", 32'(ifu.buf_speculative_o), 32'(ent.spec));
          check("entry_taken", 32'(ifu.buf_taken_o), 32'(ent.taken));
          check("entry_spec_strobe", 32'(ifu.buf_write_spec_o), 32'd1);
        end
      end

      if (ifu.flush_i) foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      if (ifu.fetch_valid_o && ifu.fetch_ready_i)
        mem_q.push_back('{addr: ifu.fetch_address_o, cyc: cyc, stale: 1'b0});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int accepts;
    rst_n_i                = 1'b0;
    ifu.flush_i            = 1'b0;
    ifu.redirect_address_i = '0;
    ifu.halt_i             = 1'b0;
    ifu.fetch_ready_i      = 1'b0;
    ifu.buf_full_i         = 1'b0;
    bp_en = 1'b0; bp_pc = '0; bp_tk = 1'b0; bp_tgt = '0;
    mem_stall = 1'b0;

    // Reset values
    repeat (3) @(posedge clk_i);
    smp();
    check("rst_fetch_valid", 32'(ifu.fetch_valid_o), 32'd0);
    check("rst_fetch_addr", ifu.fetch_address_o, RESET_ADDRESS);
    check("rst_buf_addr", ifu.buf_address_o, RESET_ADDRESS);
    check("rst_buf_flush", 32'(ifu.buf_flush_o), 32'd0);
    check("rst_wr_addr", 32'(ifu.buf_write_address_o), 32'd0);
    check("rst_wr_spec", 32'(ifu.buf_write_spec_o), 32'd0);
    check("rst_wr_instr", 32'(ifu.buf_write_instr_o), 32'd0);
    check("rst_instr", ifu.buf_instruction_o, 32'd0);
    check("rst_spec", 32'(ifu.buf_speculative_o), 32'd0);
    check("rst_taken", 32'(ifu.buf_taken_o), 32'd0);
    nxt();
    rst_n_i = 1'b1;
    smp();
    check("boot_no_fetch", 32'(ifu.fetch_valid_o), 32'd0);

    // 1: back-to-back issue, instructions one cycle behind
    for (int i = 0; i < 4; i++) begin
      expect_entry(32'(i * 4), 1'b0, 1'b0);
      issue_check("t1", 32'(i * 4));
      check("t1_instr_lag", 32'(ifu.buf_write_instr_o), 32'(i > 0));
    end
    nxt();
    ifu.fetch_ready_i = 1'b0;
    drain(3);
    check("t1_entries_done", 32'(exp_addr_q.size()), 32'd0);

    // 2: predicted-taken branch at 0x8
    nxt();
    ifu.flush_i = 1'b1;
    ifu.redirect_address_i = 32'h0;
    smp();
    check("t2_buf_flush", 32'(ifu.buf_flush_o), 32'd1);
    check("t2_flush_addr", ifu.fetch_address_o, 32'h0);
    nxt();
    ifu.flush_i = 1'b0;
    bp_en = 1'b1; bp_pc = 32'h8; bp_tk = 1'b1; bp_tgt = 32'h100;
    expect_entry(32'h0, 1'b0, 1'b0);
    expect_entry(32'h4, 1'b0, 1'b0);
    expect_entry(32'h8, 1'b1, 1'b1);
    expect_entry(32'h100, 1'b0, 1'b0);
    smp();
    issue_check("t2a", 32'h0);
    issue_check("t2b", 32'h4);
    issue_check("t2c", 32'h8);
    issue_check("t2d", 32'h100);
    nxt();
    ifu.fetch_ready_i = 1'b0;
    bp_en = 1'b0;
    drain(3);
    check("t2_entries_done", 32'(exp_addr_q.size()), 32'd0);

    // 3: flush to 0x200 with three requests in flight
    mem_stall = 1'b1;
    expect_entry(32'h104, 1'b0, 1'b0);
    expect_entry(32'h108, 1'b0, 1'b0);
    expect_entry(32'h10C, 1'b0, 1'b0);
    expect_entry(32'h200, 1'b0, 1'b0);
    issue_check("t3a", 32'h104);
    issue_check("t3b", 32'h108);
    issue_check("t3c", 32'h10C);
    nxt();
    ifu.flush_i = 1'b1;
    ifu.redirect_address_i = 32'h200;
    push_log.delete();
    smp();
    check("t3_buf_flush", 32'(ifu.buf_flush_o), 32'd1);
    check("t3_flush_valid", 32'(ifu.fetch_valid_o), 32'd1);
    check("t3_flush_addr", ifu.fetch_address_o, 32'h200);
    nxt();
    ifu.flush_i = 1'b0;
    ifu.fetch_ready_i = 1'b0;
    mem_stall = 1'b0;
    smp();
    drain(6);
    check("t3_push_count", 32'(push_log.size()), 32'd1);
    if (push_log.size() > 0) check("t3_first_push", push_log[0], mem_data(32'h200));
    check("t3_entries_done", 32'(exp_addr_q.size()), 32'd0);

    // 4: outstanding limit and buffer-full backpressure
    mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_entry(32'h204 + 32'(i * 4), 1'b0, 1'b0);
      issue_check("t4", 32'h204 + 32'(i * 4));
    end
    nxt();
    smp();
    check("t4_cap_ready1", 32'(ifu.fetch_valid_o), 32'd0);
    nxt();
    ifu.fetch_ready_i = 1'b0;
    smp();
    check("t4_cap_ready0", 32'(ifu.fetch_valid_o), 32'd0);
    mem_stall = 1'b0;
    nxt();
    smp();
    check("t4_cap_resp_cycle", 32'(ifu.fetch_valid_o), 32'd0);
    nxt();
    smp();
    check("t4_after_resp", 32'(ifu.fetch_valid_o), 32'd1);
    drain(4);
    nxt();
    ifu.buf_full_i = 1'b1;
    ifu.fetch_ready_i = 1'b1;
    smp();
    check("t4_full_valid", 32'(ifu.fetch_valid_o), 32'd0);
    check("t4_full_pc", ifu.fetch_address_o, 32'h214);
    nxt();
    smp();
    check("t4_full_pc_hold", ifu.fetch_address_o, 32'h214);
    nxt();
    ifu.buf_full_i = 1'b0;
    ifu.fetch_ready_i = 1'b0;
    smp();
    check("t4_entries_done", 32'(exp_addr_q.size()), 32'd0);

    // 5: halt stops issue but lets responses through
    mem_stall = 1'b1;
    expect_entry(32'h214, 1'b0, 1'b0);
    expect_entry(32'h218, 1'b0, 1'b0);
    expect_entry(32'h21C, 1'b0, 1'b0);
    issue_check("t5a", 32'h214);
    issue_check("t5b", 32'h218);
    nxt();
    ifu.halt_i = 1'b1;
    push_log.delete();
    smp();
    check("t5_halt_valid", 32'(ifu.fetch_valid_o), 32'd0);
    mem_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nxt();
      smp();
      check("t5_halted_valid", 32'(ifu.fetch_valid_o), 32'd0);
    end
    check("t5_halt_pushes", 32'(push_log.size()), 32'd2);
    nxt();
    ifu.halt_i = 1'b0;
    smp();
    check("t5_leave_halt", 32'(ifu.fetch_valid_o), 32'd0);
    issue_check("t5_resume", 32'h21C);
    nxt();
    ifu.fetch_ready_i = 1'b0;
    drain(3);
    check("t5_entries_done", 32'(exp_addr_q.size()), 32'd0);

    // 6: PC wrap, then a flush coinciding with a response
    nxt();
    ifu.flush_i = 1'b1;
    ifu.redirect_address_i = 32'hFFFF_FFFC;
    smp();
    mem_stall = 1'b1;
    nxt();
    ifu.flush_i = 1'b0;
    expect_entry(32'hFFFF_FFFC, 1'b0, 1'b0);
    expect_entry(32'h0000_0000, 1'b0, 1'b0);
    smp();
    issue_check("t6_top", 32'hFFFF_FFFC);
    issue_check("t6_wrap", 32'h0000_0000);
    nxt();
    ifu.fetch_ready_i = 1'b0;
    ifu.flush_i = 1'b1;
    ifu.redirect_address_i = 32'h300;
    mem_stall = 1'b0;
    smp();
    check("t6_flush_resp_drop", 32'(ifu.buf_write_instr_o), 32'd0);
    mem_stall = 1'b1;
    nxt();
    ifu.flush_i = 1'b0;
    ifu.fetch_ready_i = 1'b1;
    expect_entry(32'h300, 1'b0, 1'b0);
    expect_entry(32'h304, 1'b0, 1'b0);
    expect_entry(32'h308, 1'b0, 1'b0);
    accepts = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) nxt();
      smp();
      if (ifu.fetch_valid_o && ifu.fetch_ready_i) accepts++;
    end
    check("t6_discard_room", 32'(accepts), 32'd3);
    nxt();
    ifu.fetch_ready_i = 1'b0;
    mem_stall = 1'b0;
    smp();
    drain(6);
    check("t6_entries_done", 32'(exp_addr_q.size()), 32'd0);
    check("end_mem_idle", 32'(mem_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
